// File: rtl/regfile_write_arbiter.sv
// Purpose: merges ALU (A) and load (B) writebacks onto the single regfile write port.
// Latency: handshake at edge E -> write pulse after edge E+1; one write per cycle sustained.
// Backpressure: x_ready low in reset or while source FIFO is full (no pop bypass).
//
// Ports:
//   clock, reset                      rising-edge clock, synchronous active-low reset
//   a_valid/a_ready/a_addr/a_data     ALU writeback request channel
//   b_valid/b_ready/b_addr/b_data     load writeback request channel
//   write/wrAddr/wrData               registered regfile write port
//   busy                              work pending in either FIFO or write in flight
//   drop_cnt                          saturating count of discarded zero-register writes

// Purpose: generic synchronous FIFO, head data exposed combinationally.
// Latency: pushed entry visible at head after the push edge.
// Backpressure: full asserted at DEPTH entries; caller must gate push/pop.
//
// Ports: clock/reset, push + push_dat, pop, full, empty, head_dat.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tells full from empty.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[rd_ptr];
endmodule

module regfile_write_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int ZERO_REG   = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              write,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic              busy,
  output logic [7:0]        drop_cnt
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic {RR_A = 1'b0, RR_B = 1'b1} rr_e;

  rr_e     rr_q, rr_d;
  wr_req_t a_head, b_head;
  logic    a_full, a_empty, b_full, b_empty;
  logic    a_fire, b_fire, a_drop, b_drop, a_push, b_push;
  logic    a_grant, b_grant;
  logic [8:0] drop_sum;
  logic [7:0] drop_d;

  assign a_ready = reset & ~a_full;
  assign b_ready = reset & ~b_full;

  // Zero-register writes complete the handshake but never reach the FIFO.
  assign a_fire = a_valid & a_ready;
  assign b_fire = b_valid & b_ready;
  assign a_drop = a_fire & (a_addr == ADDR_W'(ZERO_REG));
  assign b_drop = b_fire & (b_addr == ADDR_W'(ZERO_REG));
  assign a_push = a_fire & ~a_drop;
  assign b_push = b_fire & ~b_drop;

  sync_fifo #(.W($bits(wr_req_t)), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clock    (clock),
    .reset    (reset),
    .push     (a_push),
    .push_dat ({a_addr, a_data}),
    .pop      (a_grant),
    .full     (a_full),
    .empty    (a_empty),
    .head_dat (a_head)
  );

  sync_fifo #(.W($bits(wr_req_t)), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clock    (clock),
    .reset    (reset),
    .push     (b_push),
    .push_dat ({b_addr, b_data}),
    .pop      (b_grant),
    .full     (b_full),
    .empty    (b_empty),
    .head_dat (b_head)
  );

  // Round-robin only matters under contention; a lone requester wins without touching rr.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    rr_d    = rr_q;
    if (!a_empty && !b_empty) begin
      a_grant = (rr_q == RR_A);
      b_grant = (rr_q == RR_B);
      rr_d    = (rr_q == RR_A) ? RR_B : RR_A;
    end else begin
      a_grant = ~a_empty;
      b_grant = ~b_empty;
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_cnt} + 9'(a_drop) + 9'(b_drop);
    drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  // Address/data hold their last value on idle cycles; only write marks them meaningful.
  always_ff @(posedge clock) begin
    if (!reset) begin
      write    <= 1'b0;
      wrAddr   <= '0;
      wrData   <= '0;
      drop_cnt <= '0;
      rr_q     <= RR_A;
    end else begin
      write    <= a_grant | b_grant;
      rr_q     <= rr_d;
      drop_cnt <= drop_d;
      if (a_grant) begin
        wrAddr <= a_head.addr;
        wrData <= a_head.data;
      end else if (b_grant) begin
        wrAddr <= b_head.addr;
        wrData <= b_head.data;
      end
    end
  end

  assign busy = ~a_empty | ~b_empty | write;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int ZR    = 31;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [AW-1:0] a_addr, b_addr, wrAddr;
  logic [DW-1:0] a_data, b_data, wrData;
  logic          write, busy;
  logic [7:0]    drop_cnt;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .ZERO_REG(ZR)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .write(write), .wrAddr(wrAddr), .wrData(wrData), .busy(busy), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  // Reference model: per-source queues, a "whose turn" bit and the expected write port.
  req_t          qa[$];
  req_t          qb[$];
  bit            m_turn_b;
  bit            m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_drop;
  bit            pend_a, pend_b;
  req_t          wlog[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Computes what the next rising edge must do given the inputs now applied.
  task automatic model_step();
    bit   ra, rb, ga, gb;
    int   n;
    req_t h;
    ra = reset && (qa.size() < DEPTH);
    rb = reset && (qb.size() < DEPTH);
    pend_a = a_valid && !ra;
    pend_b = b_valid && !rb;
    if (!reset) begin
      qa.delete();
      qb.delete();
      m_write  = 0;
      m_addr   = '0;
      m_data   = '0;
      m_drop   = 0;
      m_turn_b = 0;
    end else begin
      ga = (qa.size() > 0) && ((qb.size() == 0) || !m_turn_b);
      gb = (qb.size() > 0) && !ga;
      if (qa.size() > 0 && qb.size() > 0) m_turn_b = !m_turn_b;
      m_write = ga || gb;
      if (ga) begin
        h = qa.pop_front();
        m_addr = h.addr;
        m_data = h.data;
      end else if (gb) begin
        h = qb.pop_front();
        m_addr = h.addr;
        m_data = h.data;
      end
      n = 0;
      if (a_valid && ra) begin
        if (a_addr == AW'(ZR)) n++;
        else begin h.addr = a_addr; h.data = a_data; qa.push_back(h); end
      end
      if (b_valid && rb) begin
        if (b_addr == AW'(ZR)) n++;
        else begin h.addr = b_addr; h.data = b_data; qb.push_back(h); end
      end
      m_drop = (m_drop + n > 255) ? 255 : m_drop + n;
    end
  endtask

  // One clock: advance the model, let the edge happen, compare at the falling edge.
  task automatic tick();
    req_t h;
    model_step();
    @(posedge clock);
    @(negedge clock);
    chk("write", write, m_write);
    if (m_write) begin
      chk("wrAddr", wrAddr, m_addr);
      chk("wrData", wrData, m_data);
    end
    chk("busy", busy, (qa.size() > 0 || qb.size() > 0 || m_write));
    chk("drop_cnt", drop_cnt, m_drop);
    chk("a_ready", a_ready, reset && (qa.size() < DEPTH));
    chk("b_ready", b_ready, reset && (qb.size() < DEPTH));
    if (write === 1'b1) begin
      h.addr = wrAddr;
      h.data = wrData;
      wlog.push_back(h);
    end
  endtask

  initial begin
    int e3a[4] = '{1, 3, 2, 4};
    int e3d[4] = '{'h11, 'h33, 'h22, 'h44};
    int tries;

    reset = 0; a_valid = 1; a_addr = 7; a_data = 1;
    b_valid = 0; b_addr = 0; b_data = 0;
    m_turn_b = 0; m_write = 0; m_addr = '0; m_data = '0; m_drop = 0;
    pend_a = 0; pend_b = 0;

    // Reset held with a request pending
    repeat (3) begin
      tick();
      chk("rst_a_ready", a_ready, 0);
      chk("rst_write", write, 0);
      chk("rst_drop", drop_cnt, 0);
    end
    a_valid = 0; reset = 1;
    tick();
    chk("rel_a_ready", a_ready, 1);

    // Single write latency
    a_valid = 1; a_addr = 5; a_data = 64'hDEAD;
    tick();
    a_valid = 0;
    tick();
    chk("single_write", write, 1);
    chk("single_addr", wrAddr, 5);
    chk("single_data", wrData, 64'hDEAD);
    tick();
    chk("single_write_end", write, 0);
    chk("single_busy_end", busy, 0);

    // Contention ordering
    wlog.delete();
    a_valid = 1; a_addr = 1; a_data = 'h11;
    b_valid = 1; b_addr = 3; b_data = 'h33;
    tick();
    a_addr = 2; a_data = 'h22;
    b_addr = 4; b_data = 'h44;
    tick();
    a_valid = 0; b_valid = 0;
    repeat (6) tick();
    chk("contend_count", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("contend_addr", wlog[i].addr, e3a[i]);
      chk("contend_data", wlog[i].data, e3d[i]);
    end

    // Single-source stream, every request must be written in order
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      b_valid = 1; b_addr = AW'(10 + i); b_data = 64'(100 + i);
      tick();
      tries = 0;
      while (pend_b && tries < 8) begin
        tick();
        tries++;
      end
      chk("stream_accept_timeout", pend_b, 0);
    end
    b_valid = 0;
    repeat (4) tick();
    chk("stream_count", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("stream_addr", wlog[i].addr, 10 + i);
    end

    // Zero-register drops, simultaneous and saturating
    wlog.delete();
    a_valid = 1; a_addr = AW'(ZR); a_data = 0;
    b_valid = 1; b_addr = AW'(ZR); b_data = 0;
    tick();
    a_valid = 0; b_valid = 0;
    tick();
    chk("zero_drop2", drop_cnt, 2);
    chk("zero_no_write", wlog.size(), 0);
    a_valid = 1; b_valid = 1;
    repeat (150) tick();
    a_valid = 0; b_valid = 0;
    tick();
    chk("zero_saturate", drop_cnt, 255);
    chk("zero_no_write_sat", wlog.size(), 0);

    // Load both FIFOs, then reset mid-stream
    for (int k = 0; k < 6; k++) begin
      if (!pend_a) begin a_addr = AW'(k + 1); a_data = 64'(k + 'h100); end
      if (!pend_b) begin b_addr = AW'(k + 8); b_data = 64'(k + 'h200); end
      a_valid = 1; b_valid = 1;
      tick();
    end
    chk("midop_busy", busy, 1);
    reset = 0; a_valid = 0; b_valid = 0;
    tick();
    chk("midop_rst_write", write, 0);
    chk("midop_rst_busy", busy, 0);
    reset = 1;
    wlog.delete();
    repeat (3) tick();
    chk("midop_no_writes", wlog.size(), 0);
    chk("midop_idle", busy, 0);
    chk("midop_drop_clr", drop_cnt, 0);
    a_valid = 1; a_addr = 20; a_data = 'hA;
    b_valid = 1; b_addr = 21; b_data = 'hB;
    tick();
    a_valid = 0; b_valid = 0;
    tick();
    chk("midop_rr_first", wrAddr, 20);
    tick();
    chk("midop_rr_second", wrAddr, 21);
    tick();

    // Randomised traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) != 0);
      if (!pend_a) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_addr  = ($urandom_range(0, 7) == 0) ? AW'(ZR) : AW'($urandom_range(0, 31));
        a_data  = {$urandom, $urandom};
      end
      if (!pend_b) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_addr  = ($urandom_range(0, 7) == 0) ? AW'(ZR) : AW'($urandom_range(0, 31));
        b_data  = {$urandom, $urandom};
      end
      tick();
    end
    reset = 1; a_valid = 0; b_valid = 0;
    repeat (6) tick();
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
